tour_cmd_sched: RTL and testbench

Command scheduler between the UART command receiver and `cmd_proc` in the KnightsTour top level. It validates opcodes, passes calibrate and move commands straight through, and rejects invalid opcodes without disturbing `cmd_proc`. For a tour request, it hands off to tour logic, then replays the solved move list as vertical/horizontal command pairs. It is the single owner of `cmd_proc`'s command input and of the response byte returned to the remote.

---
 rtl/tour_cmd_sched_if.sv | 33 +++
 rtl/tour_cmd_sched.sv | 168 ++++++++++++++++
 tb/tb_tour_cmd_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tour_cmd_sched_if.sv
// Handshake bundle between the command scheduler, the UART command receiver,
// the tour solver and cmd_proc. The master modport is the scheduler side.
interface tour_cmd_sched_if #(
    parameter int IDX_W = 5
);
    logic [15:0]      cmd_UART;
    logic             cmd_rdy_UART;
    logic             clr_cmd_rdy_UART;
    logic             tour_go;
    logic [7:0]       tour_xy;
    logic             start_tour;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic [7:0]       resp;
    logic             resp_send;
    logic             invalid;

    modport master (
        input  cmd_UART, cmd_rdy_UART, start_tour, move, clr_cmd_rdy, send_resp,
        output clr_cmd_rdy_UART, tour_go, tour_xy, mv_indx, cmd, cmd_rdy,
               resp, resp_send, invalid
    );

    modport slave (
        output cmd_UART, cmd_rdy_UART, start_tour, move, clr_cmd_rdy, send_resp,
        input  clr_cmd_rdy_UART, tour_go, tour_xy, mv_indx, cmd, cmd_rdy,
               resp, resp_send, invalid
    );
endinterface

// File: rtl/tour_cmd_sched.sv
// Single owner of cmd_proc's command input: validates UART opcodes, passes
// calibrate/move commands through and replays a solved tour as V/H move pairs.
module tour_cmd_sched #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    tour_cmd_sched_if.master  bus
);

    typedef enum logic [2:0] {IDLE, PASS, PWAIT, SOLVE, VCMD, VWAIT, HCMD, HWAIT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    state_t           state_r;
    logic [15:0]      cmd_r;
    logic             cmd_rdy_r;
    logic             clr_uart_r;
    logic             tour_go_r;
    logic [7:0]       tour_xy_r;
    logic [IDX_W-1:0] mv_indx_r;
    logic [7:0]       resp_r;
    logic             resp_send_r;
    logic             invalid_r;
    logic             is_pass_s;
    logic             is_tour_s;
    logic             move_done_s;

    // One-hot knight move to its vertical or horizontal command; non-one-hot falls back to bit 0.
    function automatic logic [15:0] move_cmd(input logic [7:0] mv, input logic vert);
        logic       up;
        logic       east;
        logic [3:0] vmag;
        logic [3:0] hmag;
        case (mv)
            8'h02:   begin up = 1'b1; vmag = 4'd2; east = 1'b0; hmag = 4'd1; end
            8'h04:   begin up = 1'b1; vmag = 4'd1; east = 1'b0; hmag = 4'd2; end
            8'h08:   begin up = 1'b0; vmag = 4'd1; east = 1'b0; hmag = 4'd2; end
            8'h10:   begin up = 1'b0; vmag = 4'd2; east = 1'b0; hmag = 4'd1; end
            8'h20:   begin up = 1'b0; vmag = 4'd2; east = 1'b1; hmag = 4'd1; end
            8'h40:   begin up = 1'b0; vmag = 4'd1; east = 1'b1; hmag = 4'd2; end
            8'h80:   begin up = 1'b1; vmag = 4'd1; east = 1'b1; hmag = 4'd2; end
            default: begin up = 1'b1; vmag = 4'd2; east = 1'b1; hmag = 4'd1; end
        endcase
        return vert ? {4'h3, (up ? 8'h00 : 8'h7F), vmag}
                    : {4'h4, (east ? 8'hBF : 8'h3F), hmag};
    endfunction

    // Opcode classification and end-of-move detection (including the skipped HWAIT case).
    always_comb begin
        is_pass_s = 1'b0;
        is_tour_s = 1'b0;
        case (bus.cmd_UART[15:12])
            4'h2, 4'h3, 4'h4: is_pass_s = 1'b1;
            4'h6:             is_tour_s = 1'b1;
            default: begin
                is_pass_s = 1'b0;
                is_tour_s = 1'b0;
            end
        endcase
        if (state_r == HWAIT) begin
            move_done_s = bus.send_resp;
        end else if (state_r == HCMD) begin
            move_done_s = cmd_rdy_r & bus.clr_cmd_rdy & bus.send_resp;
        end else begin
            move_done_s = 1'b0;
        end
    end

    // Scheduler FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cmd_r       <= 16'h0000;
            cmd_rdy_r   <= 1'b0;
            clr_uart_r  <= 1'b0;
            tour_go_r   <= 1'b0;
            tour_xy_r   <= 8'h00;
            mv_indx_r   <= '0;
            resp_r      <= 8'h00;
            resp_send_r <= 1'b0;
            invalid_r   <= 1'b0;
        end else begin
            clr_uart_r  <= 1'b0;
            tour_go_r   <= 1'b0;
            resp_send_r <= 1'b0;
            invalid_r   <= 1'b0;
            case (state_r)
                // clr_uart_r guards against re-taking a command whose clear is still in flight
                IDLE: if (bus.cmd_rdy_UART && !clr_uart_r) begin
                    clr_uart_r <= 1'b1;
                    if (is_pass_s) begin
                        cmd_r     <= bus.cmd_UART;
                        cmd_rdy_r <= 1'b1;
                        state_r   <= PASS;
                    end else if (is_tour_s) begin
                        tour_xy_r <= bus.cmd_UART[7:0];
                        tour_go_r <= 1'b1;
                        mv_indx_r <= '0;
                        state_r   <= SOLVE;
                    end else begin
                        invalid_r <= 1'b1;
                    end
                end
                PASS: if (bus.clr_cmd_rdy) begin
                    cmd_rdy_r <= 1'b0;
                    if (bus.send_resp) begin
                        resp_r      <= 8'hA5;
                        resp_send_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= PWAIT;
                    end
                end
                PWAIT: if (bus.send_resp) begin
                    resp_r      <= 8'hA5;
                    resp_send_r <= 1'b1;
                    state_r     <= IDLE;
                end
                SOLVE: if (bus.start_tour) begin
                    state_r <= VCMD;
                end
                // First cycle loads the command from the (now stable) move index
                VCMD: if (!cmd_rdy_r) begin
                    cmd_r     <= move_cmd(bus.move, 1'b1);
                    cmd_rdy_r <= 1'b1;
                end else if (bus.clr_cmd_rdy) begin
                    cmd_rdy_r <= 1'b0;
                    state_r   <= bus.send_resp ? HCMD : VWAIT;
                end
                VWAIT: if (bus.send_resp) begin
                    state_r <= HCMD;
                end
                HCMD, HWAIT: if (move_done_s) begin
                    cmd_rdy_r   <= 1'b0;
                    resp_send_r <= 1'b1;
                    if (mv_indx_r == LAST_IDX) begin
                        resp_r  <= 8'hA5;
                        state_r <= IDLE;
                    end else begin
                        resp_r    <= 8'h5A;
                        mv_indx_r <= mv_indx_r + IDX_W'(1);
                        state_r   <= VCMD;
                    end
                end else if (state_r == HCMD && !cmd_rdy_r) begin
                    cmd_r     <= move_cmd(bus.move, 1'b0);
                    cmd_rdy_r <= 1'b1;
                end else if (state_r == HCMD && bus.clr_cmd_rdy) begin
                    cmd_rdy_r <= 1'b0;
                    state_r   <= HWAIT;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.cmd              = cmd_r;
    assign bus.cmd_rdy          = cmd_rdy_r;
    assign bus.clr_cmd_rdy_UART = clr_uart_r;
    assign bus.tour_go          = tour_go_r;
    assign bus.tour_xy          = tour_xy_r;
    assign bus.mv_indx          = mv_indx_r;
    assign bus.resp             = resp_r;
    assign bus.resp_send        = resp_send_r;
    assign bus.invalid          = invalid_r;

endmodule

// File: tb/tb_tour_cmd_sched.sv
// Directed + randomized bench for tour_cmd_sched: models the UART wrapper,
// cmd_proc and the tour move memory, and checks against a knight-move table.
module tb_tour_cmd_sched;

    logic clk = 1'b0;
    logic rst;

    tour_cmd_sched_if #(.IDX_W(5)) bus ();

    tour_cmd_sched #(.NUM_MOVES(24), .IDX_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_clr_uart = 0;
    int         n_inv = 0;
    int         n_rdy_cycles = 0;
    logic [7:0] resp_q [$];
    logic [7:0] moves [32];
    logic [15:0] last_cmd;

    assign bus.move = moves[bus.mv_indx];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, model the UART wrapper, drop input pulses.
    task automatic tick();
        @(negedge clk);
        if (bus.clr_cmd_rdy_UART === 1'b1) begin
            bus.cmd_rdy_UART = 1'b0;
            n_clr_uart++;
        end
        if (bus.invalid === 1'b1) n_inv++;
        if (bus.resp_send === 1'b1) resp_q.push_back(bus.resp);
        if (bus.cmd_rdy === 1'b1) n_rdy_cycles++;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.start_tour  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd"},       32'(bus.cmd), 32'h0);
        chk({tag, "_tour_xy"},   32'(bus.tour_xy), 32'h0);
        chk({tag, "_mv_indx"},   32'(bus.mv_indx), 32'h0);
        chk({tag, "_resp"},      32'(bus.resp), 32'h0);
        chk({tag, "_cmd_rdy"},   32'(bus.cmd_rdy), 32'h0);
        chk({tag, "_clr_uart"},  32'(bus.clr_cmd_rdy_UART), 32'h0);
        chk({tag, "_tour_go"},   32'(bus.tour_go), 32'h0);
        chk({tag, "_resp_send"}, 32'(bus.resp_send), 32'h0);
        chk({tag, "_invalid"},   32'(bus.invalid), 32'h0);
    endtask

    // cmd_proc model: wait for a command, accept it, finish it (optionally in the same cycle).
    task automatic serve(input bit together, output logic [15:0] got);
        int waited = 0;
        while (bus.cmd_rdy !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("cmd_rdy_wait", 32'(bus.cmd_rdy), 32'h1);
        got = bus.cmd;
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("cmd_rdy_hold", 32'(bus.cmd_rdy), 32'h1);
        end
        bus.clr_cmd_rdy = 1'b1;
        bus.send_resp   = together;
        tick();
        chk("cmd_rdy_drop", 32'(bus.cmd_rdy), 32'h0);
        if (!together) begin
            repeat ($urandom_range(0, 3)) tick();
            bus.send_resp = 1'b1;
            tick();
        end
    endtask

    task automatic do_pass(input logic [15:0] c, input bit together);
        logic [15:0] got;
        bus.cmd_UART     = c;
        bus.cmd_rdy_UART = 1'b1;
        tick();
        chk("pass_cmd_rdy",  32'(bus.cmd_rdy), 32'h1);
        chk("pass_cmd",      32'(bus.cmd), 32'(c));
        chk("pass_clr_uart", 32'(bus.clr_cmd_rdy_UART), 32'h1);
        serve(together, got);
        chk("pass_resp_send", 32'(bus.resp_send), 32'h1);
        chk("pass_resp",      32'(bus.resp), 32'hA5);
        tick();
        chk("pass_resp_pulse", 32'(bus.resp_send), 32'h0);
        last_cmd = c;
    endtask

    // Reference: knight move as (dy,dx), turned into the two commands from plain arithmetic.
    function automatic void exp_cmds(input logic [7:0] mv, output logic [15:0] v, output logic [15:0] h);
        int dys [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
        int dxs [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
        int b = 0;
        for (int k = 0; k < 8; k++) if (mv[k]) b = k;
        v = {4'h3, (dys[b] > 0) ? 8'h00 : 8'h7F, 4'((dys[b] > 0) ? dys[b] : -dys[b])};
        h = {4'h4, (dxs[b] > 0) ? 8'hBF : 8'h3F, 4'((dxs[b] > 0) ? dxs[b] : -dxs[b])};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, i0, r0, q0, held_c0, n5a, w;
        logic [15:0] got, ev, eh;
        logic [3:0]  op4;

        bus.cmd_UART = 16'h0000; bus.cmd_rdy_UART = 1'b0; bus.start_tour = 1'b0;
        bus.clr_cmd_rdy = 1'b0;  bus.send_resp = 1'b0;
        for (int k = 0; k < 32; k++) moves[k] = 8'h01;
        last_cmd = 16'h0000;

        rst = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Every invalid opcode: one clear, one invalid pulse, nothing else.
        for (int op = 0; op < 16; op++) begin
            if (!(op inside {2, 3, 4, 6})) begin
                c0 = n_clr_uart; i0 = n_inv; r0 = n_rdy_cycles; q0 = resp_q.size();
                bus.cmd_UART     = {4'(op), 12'hFFF};
                bus.cmd_rdy_UART = 1'b1;
                tick();
                chk("inv_pulse", 32'(bus.invalid), 32'h1);
                chk("inv_clr",   32'(bus.clr_cmd_rdy_UART), 32'h1);
                repeat (11) tick();
                chk("inv_clr_count", 32'(n_clr_uart - c0), 32'h1);
                chk("inv_count",     32'(n_inv - i0), 32'h1);
                chk("inv_no_rdy",    32'(n_rdy_cycles - r0), 32'h0);
                chk("inv_no_resp",   32'(resp_q.size() - q0), 32'h0);
                chk("inv_cmd_kept",  32'(bus.cmd), 32'(last_cmd));
            end
        end

        do_pass(16'h2000, 1'b0);
        for (int n = 0; n < 6; n++) begin
            case ($urandom_range(0, 2))
                0:       op4 = 4'h2;
                1:       op4 = 4'h3;
                default: op4 = 4'h4;
            endcase
            do_pass({op4, 12'($urandom)}, 1'($urandom_range(0, 1)));
        end

        // Full tour from 8'h22; first move is bit 0, a UART command arrives mid-tour.
        moves[0] = 8'h01;
        for (int k = 1; k < 24; k++) moves[k] = 8'h01 << $urandom_range(0, 7);
        q0 = resp_q.size();
        held_c0 = 0;
        bus.cmd_UART = 16'h6022; bus.cmd_rdy_UART = 1'b1;
        tick();
        chk("tour_go",       32'(bus.tour_go), 32'h1);
        chk("tour_xy",       32'(bus.tour_xy), 32'h22);
        chk("tour_clr_uart", 32'(bus.clr_cmd_rdy_UART), 32'h1);
        chk("tour_idx0",     32'(bus.mv_indx), 32'h0);
        repeat (3) begin
            tick();
            chk("solve_no_cmd", 32'(bus.cmd_rdy), 32'h0);
        end
        bus.start_tour = 1'b1;
        tick();
        for (int i = 0; i < 24; i++) begin
            exp_cmds(moves[i], ev, eh);
            if (i == 10) begin
                bus.cmd_UART = 16'h3001; bus.cmd_rdy_UART = 1'b1;
                held_c0 = n_clr_uart;
            end
            serve(1'($urandom_range(0, 1)), got);
            chk("v_cmd", 32'(got), 32'(ev));
            if (i == 0) chk("first_v_cmd", 32'(got), 32'h3002);
            chk("v_idx", 32'(bus.mv_indx), 32'(i));
            chk("v_no_resp", 32'(bus.resp_send), 32'h0);
            serve(1'($urandom_range(0, 1)), got);
            chk("h_cmd", 32'(got), 32'(eh));
            if (i == 0) chk("first_h_cmd", 32'(got), 32'h4BF1);
            chk("h_resp_send", 32'(bus.resp_send), 32'h1);
            chk("h_resp", 32'(bus.resp), (i == 23) ? 32'hA5 : 32'h5A);
        end
        chk("tour_end_idx", 32'(bus.mv_indx), 32'd23);
        chk("held_not_cleared", 32'(n_clr_uart - held_c0), 32'h0);
        n5a = 0;
        for (int k = q0; k < resp_q.size() - 1; k++) if (resp_q[k] == 8'h5A) n5a++;
        chk("tour_resp_count", 32'(resp_q.size() - q0), 32'd24);
        chk("tour_5a_count",   32'(n5a), 32'd23);
        chk("tour_last_resp",  32'(resp_q[resp_q.size() - 1]), 32'hA5);
        tick();
        chk("held_clr_uart", 32'(bus.clr_cmd_rdy_UART), 32'h1);
        chk("held_cmd_rdy",  32'(bus.cmd_rdy), 32'h1);
        chk("held_cmd",      32'(bus.cmd), 32'h3001);
        serve(1'b0, got);
        chk("held_resp", 32'(bus.resp), 32'hA5);
        tick();

        // Reset while waiting for the vertical command to finish.
        bus.cmd_UART = 16'h6013; bus.cmd_rdy_UART = 1'b1;
        tick();
        chk("rst_tour_go", 32'(bus.tour_go), 32'h1);
        bus.start_tour = 1'b1;
        tick();
        w = 0;
        while (bus.cmd_rdy !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("rst_tour_rdy", 32'(bus.cmd_rdy), 32'h1);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        chk("rst_vwait_rdy", 32'(bus.cmd_rdy), 32'h0);
        rst = 1'b1;
        tick();
        check_reset_vals("mid_rst");
        rst = 1'b0;
        q0 = resp_q.size(); r0 = n_rdy_cycles;
        repeat (5) tick();
        chk("post_rst_no_resp", 32'(resp_q.size() - q0), 32'h0);
        chk("post_rst_no_cmd",  32'(n_rdy_cycles - r0), 32'h0);
        do_pass(16'h4BF1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
